// File: rtl/train_control_es.sv
// Epoch sequencer: train/validate phases, tracks best validation error, pulses SAVE on improvement, early-stops on patience.
// Strobes take effect at the next edge; SAVE is combinational in the single EVAL cycle; no backpressure, stray strobes are dropped.
module train_control_es #(
  parameter int BITS     = 16,
  parameter int ERR_BITS = 16,
  parameter int PAT_BITS = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [BITS-1:0]          TRAIN,
  input  logic [BITS-1:0]          VALID,
  input  logic [BITS-1:0]          EPOCH,
  input  logic [PAT_BITS-1:0]      PATIENCE,
  input  logic [ERR_BITS-1:0]      Error,
  input  logic                     S_Train,
  input  logic                     S_Error,
  input  logic                     Start,
  input  logic                     Abort,
  output logic                     TR,
  output logic                     VL,
  output logic                     SAVE,
  output logic                     END,
  output logic                     EARLY,
  output logic [BITS-1:0]          EPOCH_CNT,
  output logic [ERR_BITS+BITS-1:0] BEST_ERR
);
  localparam int AW = ERR_BITS + BITS;
  localparam logic [BITS-1:0] ONE = BITS'(1);

  typedef enum logic [2:0] {ST_IDLE, ST_TRAIN, ST_VALID, ST_EVAL, ST_DONE} state_t;

  state_t              state, state_n;
  logic [BITS-1:0]     train_sh, valid_sh, epoch_sh, cnt;
  logic [PAT_BITS-1:0] pat_sh, stall, stall_n;
  logic [AW-1:0]       acc;
  logic                best_valid, early, improved, last_epoch, pat_stop;

  always_comb begin
    improved   = !best_valid || (acc < BEST_ERR);
    stall_n    = improved ? '0 : ((stall == {PAT_BITS{1'b1}}) ? stall : stall + 1'b1);
    last_epoch = (EPOCH_CNT + ONE) == epoch_sh;
    pat_stop   = (pat_sh != '0) && (stall_n == pat_sh);
    state_n    = state;
    SAVE       = 1'b0;
    case (state)
      ST_IDLE, ST_DONE: begin
        // Config comes straight from the ports here; shadows load on this same edge.
        if (Start) begin
          if (EPOCH == '0)      state_n = ST_DONE;
          else if (TRAIN == '0) state_n = ST_VALID;
          else                  state_n = ST_TRAIN;
        end
      end
      ST_TRAIN: begin
        if (Abort) state_n = ST_DONE;
        else if (S_Train && cnt == train_sh - ONE)
          state_n = (valid_sh == '0) ? ST_EVAL : ST_VALID;
      end
      ST_VALID: begin
        if (Abort) state_n = ST_DONE;
        else if (S_Error && cnt == valid_sh - ONE) state_n = ST_EVAL;
      end
      ST_EVAL: begin
        if (Abort) state_n = ST_DONE;
        else begin
          SAVE = improved;
          if (last_epoch || pat_stop) state_n = ST_DONE;
          else state_n = (train_sh == '0) ? ST_VALID : ST_TRAIN;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_n;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      train_sh   <= '0;
      valid_sh   <= '0;
      epoch_sh   <= '0;
      pat_sh     <= '0;
      cnt        <= '0;
      acc        <= '0;
      stall      <= '0;
      EPOCH_CNT  <= '0;
      BEST_ERR   <= '1;
      best_valid <= 1'b0;
      early      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (Start) begin
            train_sh   <= TRAIN;
            valid_sh   <= VALID;
            epoch_sh   <= EPOCH;
            pat_sh     <= PATIENCE;
            cnt        <= '0;
            acc        <= '0;
            stall      <= '0;
            EPOCH_CNT  <= '0;
            BEST_ERR   <= '1;
            best_valid <= 1'b0;
            early      <= 1'b0;
          end
        end
        ST_TRAIN: begin
          if (!Abort && S_Train) cnt <= (state_n != ST_TRAIN) ? '0 : cnt + ONE;
        end
        ST_VALID: begin
          if (!Abort && S_Error) begin
            acc <= acc + AW'(Error);
            cnt <= (state_n == ST_EVAL) ? '0 : cnt + ONE;
          end
        end
        ST_EVAL: begin
          // An abort here discards the epoch entirely: no count, no best update.
          if (!Abort) begin
            if (improved) begin
              BEST_ERR   <= acc;
              best_valid <= 1'b1;
            end
            stall     <= stall_n;
            EPOCH_CNT <= EPOCH_CNT + ONE;
            acc       <= '0;
            cnt       <= '0;
            early     <= !last_epoch && pat_stop;
          end
        end
        default: ;
      endcase
    end
  end

  assign TR    = (state == ST_TRAIN);
  assign VL    = (state == ST_VALID);
  assign END   = (state == ST_DONE);
  assign EARLY = early;

endmodule

// File: tb/tb_train_control_es.sv
// Directed bench for train_control_es with an epoch-level reference model checked every cycle.
module tb_train_control_es;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] TRAIN = '0, VALID = '0, EPOCH = '0, Error = '0;
  logic [3:0]  PATIENCE = '0;
  logic        S_Train = 1'b0, S_Error = 1'b0, Start = 1'b0, Abort = 1'b0;
  logic        TR, VL, SAVE, END, EARLY;
  logic [15:0] EPOCH_CNT;
  logic [31:0] BEST_ERR;

  train_control_es #(.BITS(16), .ERR_BITS(16), .PAT_BITS(4)) dut (
    .clk(clk), .rst(rst), .TRAIN(TRAIN), .VALID(VALID), .EPOCH(EPOCH),
    .PATIENCE(PATIENCE), .Error(Error), .S_Train(S_Train), .S_Error(S_Error),
    .Start(Start), .Abort(Abort), .TR(TR), .VL(VL), .SAVE(SAVE), .END(END),
    .EARLY(EARLY), .EPOCH_CNT(EPOCH_CNT), .BEST_ERR(BEST_ERR)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int saves  = 0;

  // Reference model: run status, phase within the epoch, running sums.
  bit     m_active, m_done, m_early, m_bv, e_save;
  int     m_phase, m_n, m_ep, m_stall;
  int     c_train, c_valid, c_epoch, c_pat;
  longint m_sum, m_best;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      m_active = 0; m_done = 0; m_early = 0; m_bv = 0;
      m_phase = 0; m_n = 0; m_ep = 0; m_stall = 0;
      m_sum = 0; m_best = 64'hFFFF_FFFF;
    end
    e_save = m_active && m_phase == 2 && !Abort && (!m_bv || m_sum < m_best);
    chk("TR", TR, m_active && m_phase == 0);
    chk("VL", VL, m_active && m_phase == 1);
    chk("SAVE", SAVE, e_save);
    chk("END", END, m_done);
    chk("EARLY", EARLY, m_early);
    chk("EPOCH_CNT", EPOCH_CNT, m_ep);
    chk("BEST_ERR", BEST_ERR, m_best);
    if (SAVE) saves++;
    if (!rst) begin
      if (!m_active) begin
        if (Start) begin
          c_train = TRAIN; c_valid = VALID; c_epoch = EPOCH; c_pat = PATIENCE;
          m_ep = 0; m_best = 64'hFFFF_FFFF; m_bv = 0; m_stall = 0;
          m_sum = 0; m_n = 0; m_early = 0;
          if (c_epoch == 0) m_done = 1;
          else begin
            m_done = 0; m_active = 1; m_phase = (c_train == 0) ? 1 : 0;
          end
        end
      end else if (Abort) begin
        m_active = 0; m_done = 1; m_early = 0;
      end else if (m_phase == 0) begin
        if (S_Train) begin
          m_n++;
          if (m_n == c_train) begin m_n = 0; m_phase = (c_valid == 0) ? 2 : 1; end
        end
      end else if (m_phase == 1) begin
        if (S_Error) begin
          m_sum += Error;
          m_n++;
          if (m_n == c_valid) begin m_n = 0; m_phase = 2; end
        end
      end else begin
        if (e_save) begin m_best = m_sum; m_bv = 1; m_stall = 0; end
        else if (m_stall < 15) m_stall++;
        m_ep++;
        m_sum = 0;
        if (m_ep == c_epoch) begin m_active = 0; m_done = 1; m_early = 0; end
        else if (c_pat != 0 && m_stall == c_pat) begin m_active = 0; m_done = 1; m_early = 1; end
        else m_phase = (c_train == 0) ? 1 : 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_run(input int tr, input int va, input int ep, input int pa);
    tick();
    TRAIN = 16'(tr); VALID = 16'(va); EPOCH = 16'(ep); PATIENCE = 4'(pa);
    Start = 1; S_Train = 0; S_Error = 0; Abort = 0;
    tick();
    Start = 0;
    // Scramble the config ports: the run must keep using the latched values.
    TRAIN = 16'd7; VALID = 16'd3; EPOCH = 16'd1; PATIENCE = 4'd1;
  endtask

  // mode 0: Error ramps +2 every 4 cycles; 1: constant base; 2: base - 2*epoch
  task automatic run(input string name, input int budget, input bit tog, input int mode, input int base);
    int cyc;
    bit ok;
    cyc = 0;
    ok  = 0;
    while (cyc < budget) begin
      S_Train = tog ? cyc[0] : 1'b1;
      S_Error = tog ? cyc[0] : 1'b1;
      case (mode)
        0:       Error = 16'((cyc / 4) * 2);
        1:       Error = 16'(base);
        default: Error = 16'(base - 2 * m_ep);
      endcase
      tick();
      cyc++;
      if (END) begin ok = 1; break; end
    end
    S_Train = 0; S_Error = 0;
    chk({name, "_end_reached"}, ok, 1);
  endtask

  int  base_saves;
  bit  found;

  initial begin
    repeat (2) tick();
    rst = 0;

    // Ramp errors: epoch 1 sum 140, epoch 2 sum 340
    start_run(10, 10, 2, 0);
    base_saves = saves;
    run("ramp", 300, 1, 0, 0);
    chk("ramp_END", END, 1);
    chk("ramp_EARLY", EARLY, 0);
    chk("ramp_EPOCH_CNT", EPOCH_CNT, 2);
    chk("ramp_BEST", BEST_ERR, 140);
    chk("ramp_saves", saves - base_saves, 1);

    // Constant error 5, patience 2
    start_run(4, 4, 10, 2);
    base_saves = saves;
    run("pat", 300, 0, 1, 5);
    chk("pat_BEST", BEST_ERR, 20);
    chk("pat_EARLY", EARLY, 1);
    chk("pat_EPOCH_CNT", EPOCH_CNT, 3);
    chk("pat_saves", saves - base_saves, 1);

    // Decreasing error 8,6,4 per sample
    start_run(3, 2, 3, 0);
    base_saves = saves;
    run("dec", 300, 1, 2, 8);
    chk("dec_BEST", BEST_ERR, 8);
    chk("dec_EARLY", EARLY, 0);
    chk("dec_EPOCH_CNT", EPOCH_CNT, 3);
    chk("dec_saves", saves - base_saves, 3);

    // Abort mid-VALID of epoch 2
    start_run(3, 4, 5, 0);
    S_Train = 1; S_Error = 1; Error = 16'd5;
    found = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (m_active && m_ep == 1 && m_phase == 1 && m_n == 2) begin found = 1; break; end
    end
    chk("abort_point_reached", found, 1);
    Abort = 1;
    base_saves = saves;
    tick();
    Abort = 0; S_Train = 0; S_Error = 0;
    chk("abort_END", END, 1);
    chk("abort_TR", TR, 0);
    chk("abort_VL", VL, 0);
    chk("abort_EPOCH_CNT", EPOCH_CNT, 1);
    chk("abort_saves", saves - base_saves, 0);
    start_run(3, 4, 5, 0);
    chk("restart_END", END, 0);
    chk("restart_TR", TR, 1);
    chk("restart_EPOCH_CNT", EPOCH_CNT, 0);
    chk("restart_BEST", BEST_ERR, 64'hFFFF_FFFF);

    // Start ignored mid-TRAIN, then async reset
    S_Train = 1; tick(); S_Train = 0;
    TRAIN = 16'd0; EPOCH = 16'd0; Start = 1; tick(); Start = 0;
    chk("ign_start_TR", TR, 1);
    chk("ign_start_END", END, 0);
    #2 rst = 1;
    #1;
    chk("arst_TR", TR, 0);
    chk("arst_END", END, 0);
    chk("arst_EPOCH_CNT", EPOCH_CNT, 0);
    chk("arst_BEST", BEST_ERR, 64'hFFFF_FFFF);
    tick();
    rst = 0;

    // EPOCH=0
    start_run(5, 5, 0, 0);
    chk("e0_END", END, 1);
    chk("e0_TR", TR, 0);
    chk("e0_EPOCH_CNT", EPOCH_CNT, 0);

    // TRAIN=0
    start_run(0, 2, 1, 0);
    chk("t0_VL", VL, 1);
    chk("t0_TR", TR, 0);
    run("t0", 50, 0, 1, 3);
    chk("t0_BEST", BEST_ERR, 6);
    chk("t0_EPOCH_CNT", EPOCH_CNT, 1);

    // VALID=0
    start_run(2, 0, 3, 0);
    base_saves = saves;
    run("v0", 50, 0, 1, 9);
    chk("v0_BEST", BEST_ERR, 0);
    chk("v0_EPOCH_CNT", EPOCH_CNT, 3);
    chk("v0_saves", saves - base_saves, 1);

    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
endmodule

// File: doc/train_control_es.md
Name: train_control_es

Overview:
- Parametrised next-generation training sequencer for the neural-net datapath.
- Runs repeated epochs. Each epoch is a train phase of TRAIN samples followed by a validation phase of VALID samples.
- Accumulates validation error per epoch and keeps the best (lowest) epoch error. Pulses SAVE so weights are stored on each improvement.
- Stops after EPOCH epochs, or earlier when PATIENCE consecutive epochs show no improvement.

Parameters:
- BITS, 16, width of sample/epoch counters and of TRAIN/VALID/EPOCH.
- ERR_BITS, 16, width of per-sample Error input.
- PAT_BITS, 4, width of PATIENCE and of the stall counter.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- TRAIN  in  BITS  training samples per epoch.
- VALID  in  BITS  validation samples per epoch.
- EPOCH  in  BITS  maximum epochs.
- PATIENCE  in  PAT_BITS  non-improving epochs before early stop; 0 disables early stop.
- Error  in  ERR_BITS  unsigned error of current validation sample.
- S_Train  in  1  one training sample completed (per high cycle).
- S_Error  in  1  Error valid for one validation sample (per high cycle).
- Start  in  1  begin a run.
- Abort  in  1  terminate the run.
- TR  out  1  train phase active.
- VL  out  1  validation phase active.
- SAVE  out  1  one-cycle pulse: store current weights.
- END  out  1  run finished; held.
- EARLY  out  1  run ended by patience.
- EPOCH_CNT  out  BITS  completed epochs.
- BEST_ERR  out  ERR_BITS+BITS  lowest epoch error sum so far.

Behaviour:
- Reset (async, any state): state IDLE. All counters cleared. TR=VL=SAVE=END=EARLY=0, EPOCH_CNT=0, BEST_ERR=all ones, best_valid=0.
- States: IDLE, TRAIN, VALID, EVAL, DONE.

State transitions:
- IDLE/DONE, Start=1 at edge:
  - Latch TRAIN/VALID/EPOCH/PATIENCE into shadow registers.
  - Clear EPOCH_CNT, stall, sample counter and accumulator. BEST_ERR=all ones, best_valid=0. Clear END and EARLY.
  - Next state: DONE if latched EPOCH==0 (END=1, EARLY=0); else VALID if latched TRAIN==0; else TRAIN.
- TRAIN (TR=1):
  - Each edge with S_Train=1 increments the sample counter.
  - On the edge where the count reaches latched TRAIN: clear the counter, next state VALID (or EVAL if latched VALID==0).
  - TR drops the cycle after the last counted strobe.
- VALID (VL=1):
  - Each edge with S_Error=1 adds zero-extended Error to the accumulator and increments the counter.
  - On reaching latched VALID: next state EVAL. The final sample is included in the sum.
  - The accumulator is ERR_BITS+BITS wide; no overflow is possible.
- EVAL (exactly one cycle, TR=VL=0):
  - improved = !best_valid or acc < BEST_ERR (strict).
  - If improved: SAVE=1 this cycle, BEST_ERR<=acc, best_valid<=1, stall<=0. Otherwise stall<=stall+1, with no wrap (saturates).
  - EPOCH_CNT<=EPOCH_CNT+1. Accumulator and counter are cleared.
  - Next state DONE if EPOCH_CNT+1==latched EPOCH (EARLY=0).
  - Else DONE if PATIENCE!=0 and the new stall==PATIENCE (EARLY=1).
  - Else TRAIN (or VALID if latched TRAIN==0).
- DONE: END=1 and EARLY are held, and EPOCH_CNT/BEST_ERR are frozen, until Start or rst.

Input handling:
- Strobes in the wrong state are ignored: S_Train outside TRAIN, S_Error outside VALID, both strobes in EVAL/IDLE/DONE.
- Start in TRAIN/VALID/EVAL is ignored.
- Abort in TRAIN/VALID/EVAL → DONE at the next edge: END=1, EARLY=0, no SAVE, and the partial epoch is not counted. Abort has priority over EVAL actions. Abort in IDLE/DONE is ignored.
- Config inputs may change mid-run without effect, since the shadow registers are used.

Test Plan:
- TRAIN=10, VALID=10, EPOCH=2, PATIENCE=0, S_Train/S_Error toggling, Error ramp +2 every 40 ns from 0 → TR for 10 strobes, then VL for 10; SAVE pulses in epoch 1 only (epoch 2 sum larger); END=1, EARLY=0, EPOCH_CNT=2.
- TRAIN=4, VALID=4, EPOCH=10, PATIENCE=2, Error constant 5 → BEST_ERR=20 with SAVE in epoch 1 only; END after epoch 3; EARLY=1; EPOCH_CNT=3.
- Error decreasing each epoch (8,6,4 per sample, VALID=2, EPOCH=3) → SAVE every epoch; BEST_ERR=8; END, EARLY=0.
- Abort asserted mid-VALID of epoch 2 → next cycle END=1, TR=VL=0, no SAVE, EPOCH_CNT=1; a subsequent Start restarts from epoch 0.
- rst asserted mid-TRAIN asynchronously → outputs immediately take reset values; Start pulses during TRAIN are ignored.
- Edge configs: EPOCH=0 → END one cycle after Start with EPOCH_CNT=0; TRAIN=0 → TR never asserts and VL follows Start directly; VALID=0 → acc=0, SAVE in epoch 1 only.
